// File: rtl/sys_ctrl_tx_queue.sv
// Tx-side result queue: buffers ALU/register-file results in a small FIFO and
// serialises each entry LSB-byte-first to the UART Tx with a one-cycle gap per byte.
module sys_ctrl_tx_queue #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ALU_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ALU_WIDTH-1:0]  ALU_OUT,
  input  logic                  OUT_Valid,
  input  logic [DATA_WIDTH-1:0] RdData,
  input  logic                  RdData_Valid,
  input  logic                  Busy,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  output logic                  FIFO_FULL,
  output logic                  OVERFLOW
);

  localparam int unsigned NBytes = ALU_WIDTH / DATA_WIDTH;
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned BlW    = $clog2(NBytes + 1);
  localparam int unsigned EntryW = ALU_WIDTH + 1;

  if ((ALU_WIDTH % DATA_WIDTH) != 0) begin : g_bad_width
    $error("ALU_WIDTH must be a multiple of DATA_WIDTH");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 2");
  end

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  state_e                 state_q, state_d;
  logic [EntryW-1:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr1_ptr;
  logic [CntW-1:0]        count_q, count_d, free_slots, n_push;
  logic [ALU_WIDTH-1:0]   shift_q, shift_d;
  logic [BlW-1:0]         bytes_left_q, bytes_left_d;
  logic [DATA_WIDTH-1:0]  tx_data_q, tx_data_d;
  logic                   overflow_q, overflow_d;
  logic                   wr0_en, wr1_en, pop, drop;
  logic [EntryW-1:0]      wr0_data, wr1_data, alu_entry, rd_entry, head;

  assign alu_entry = {1'b1, ALU_OUT};
  assign rd_entry  = {1'b0, ALU_WIDTH'(RdData)};
  assign head      = mem_q[rd_ptr_q];
  assign wr1_ptr   = wr_ptr_q + PtrW'(1);

  // Slot accounting uses the count at cycle start; a same-cycle pop frees nothing.
  always_comb begin
    free_slots = CntW'(FIFO_DEPTH) - count_q;
    wr0_en     = 1'b0;
    wr1_en     = 1'b0;
    wr0_data   = alu_entry;
    wr1_data   = rd_entry;
    drop       = 1'b0;
    if (OUT_Valid && RdData_Valid) begin
      if (free_slots >= CntW'(2)) begin
        wr0_en = 1'b1;
        wr1_en = 1'b1;
      end else if (free_slots == CntW'(1)) begin
        wr0_en = 1'b1;
        drop   = 1'b1;
      end else begin
        drop   = 1'b1;
      end
    end else if (OUT_Valid) begin
      if (free_slots != '0) wr0_en = 1'b1;
      else                  drop   = 1'b1;
    end else if (RdData_Valid) begin
      wr0_data = rd_entry;
      if (free_slots != '0) wr0_en = 1'b1;
      else                  drop   = 1'b1;
    end
  end

  always_comb begin
    n_push     = CntW'(wr0_en) + CntW'(wr1_en);
    count_d    = count_q + n_push - CntW'(pop);
    wr_ptr_d   = wr_ptr_q + PtrW'(n_push);
    rd_ptr_d   = rd_ptr_q + PtrW'(pop);
    overflow_d = overflow_q | drop;
  end

  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    shift_d      = shift_q;
    bytes_left_d = bytes_left_q;
    tx_data_d    = tx_data_q;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          pop          = 1'b1;
          shift_d      = head[ALU_WIDTH-1:0];
          bytes_left_d = head[ALU_WIDTH] ? BlW'(NBytes) : BlW'(1);
          tx_data_d    = head[DATA_WIDTH-1:0];
          state_d      = StSend;
        end
      end
      StSend: begin
        if (!Busy) begin
          shift_d      = shift_q >> DATA_WIDTH;
          bytes_left_d = bytes_left_q - BlW'(1);
          state_d      = StGap;
        end
      end
      StGap: begin
        // Gap cycle lets Tx raise Busy before the next byte is offered.
        if (bytes_left_q != '0) begin
          tx_data_d = shift_q[DATA_WIDTH-1:0];
          state_d   = StSend;
        end else begin
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      shift_q      <= '0;
      bytes_left_q <= '0;
      tx_data_q    <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      shift_q      <= shift_d;
      bytes_left_q <= bytes_left_d;
      tx_data_q    <= tx_data_d;
      overflow_q   <= overflow_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge CLK) begin
    if (wr0_en) mem_q[wr_ptr_q] <= wr0_data;
    if (wr1_en) mem_q[wr1_ptr]  <= wr1_data;
  end

  assign TX_P_DATA = tx_data_q;
  assign TX_D_VLD  = (state_q == StSend);
  assign FIFO_FULL = (count_q == CntW'(FIFO_DEPTH));
  assign OVERFLOW  = overflow_q;

endmodule

// File: tb/tb_sys_ctrl_tx_queue.sv
// Directed bench for sys_ctrl_tx_queue: per-cycle vector table plus hand-written
// sequences for busy hold, mid-operation reset and overflow.
module tb_sys_ctrl_tx_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] alu_out;
  logic        out_valid;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        busy;
  logic [7:0]  tx_data;
  logic        tx_vld;
  logic        full;
  logic        ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sys_ctrl_tx_queue #(
    .DATA_WIDTH(8),
    .ALU_WIDTH (16),
    .FIFO_DEPTH(4)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .ALU_OUT     (alu_out),
    .OUT_Valid   (out_valid),
    .RdData      (rd_data),
    .RdData_Valid(rd_valid),
    .Busy        (busy),
    .TX_P_DATA   (tx_data),
    .TX_D_VLD    (tx_vld),
    .FIFO_FULL   (full),
    .OVERFLOW    (ovf)
  );

  typedef struct {
    logic        av;
    logic [15:0] alu;
    logic        rv;
    logic [7:0]  rd;
    logic        vld;
    logic [7:0]  data;
  } vec_t;

  vec_t vq[$];

  task automatic v(input logic av, input logic [15:0] alu, input logic rv, input logic [7:0] rd,
                   input logic vld, input logic [7:0] data);
    vec_t e;
    e.av = av; e.alu = alu; e.rv = rv; e.rd = rd; e.vld = vld; e.data = data;
    vq.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [15:0] alu, input logic rv,
                       input logic [7:0] rd);
    out_valid = av; alu_out = alu; rd_valid = rv; rd_data = rd;
  endtask

  // Collects n bytes with Busy low; each byte must be followed by a VLD=0 gap cycle.
  task automatic drain(input logic [7:0] exp [8], input int n, input string name);
    for (int b = 0; b < n; b++) begin
      int waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (!tx_vld && waited < 20);
      check($sformatf("%s_vld%0d", name, b), 32'(tx_vld), 32'd1);
      check($sformatf("%s_byte%0d", name, b), 32'(tx_data), 32'(exp[b]));
      @(negedge clk);
      check($sformatf("%s_gap%0d", name, b), 32'(tx_vld), 32'd0);
    end
  endtask

  task automatic expect_quiet(input int cycles, input string name);
    int pulses = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (tx_vld) pulses++;
    end
    check(name, 32'(pulses), 32'd0);
  endtask

  initial begin
    logic [7:0] exp [8];
    rst  = 1'b0;
    busy = 1'b0;

    // Reset held two cycles with random inputs.
    for (int c = 0; c < 2; c++) begin
      drive(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), 8'($urandom));
      busy = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    check("reset_outputs", {21'd0, tx_vld, tx_data, full, ovf}, 32'd0);
    rst  = 1'b1;
    busy = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 8'h0);
    expect_quiet(4, "reset_no_pulse");

    // Rd path, ALU split, simultaneous ALU+Rd; one row per cycle.
    v(0, 16'h0000, 1, 8'hA5, 0, 8'h00);
    v(0, 16'h0000, 0, 8'h00, 0, 8'h00);
    v(0, 16'h0000, 0, 8'h00, 1, 8'hA5);
    v(0, 16'h0000, 0, 8'h00, 0, 8'hA5);
    v(1, 16'h1234, 0, 8'h00, 0, 8'hA5);
    v(0, 16'h0000, 0, 8'h00, 0, 8'hA5);
    v(0, 16'h0000, 0, 8'h00, 1, 8'h34);
    v(0, 16'h0000, 0, 8'h00, 0, 8'h34);
    v(0, 16'h0000, 0, 8'h00, 1, 8'h12);
    v(0, 16'h0000, 0, 8'h00, 0, 8'h12);
    v(1, 16'hBEEF, 1, 8'h0C, 0, 8'h12);
    v(0, 16'h0000, 0, 8'h00, 0, 8'h12);
    v(0, 16'h0000, 0, 8'h00, 1, 8'hEF);
    v(0, 16'h0000, 0, 8'h00, 0, 8'hEF);
    v(0, 16'h0000, 0, 8'h00, 1, 8'hBE);
    v(0, 16'h0000, 0, 8'h00, 0, 8'hBE);
    v(0, 16'h0000, 0, 8'h00, 0, 8'hBE);
    v(0, 16'h0000, 0, 8'h00, 1, 8'h0C);
    v(0, 16'h0000, 0, 8'h00, 0, 8'h0C);
    v(0, 16'h0000, 0, 8'h00, 0, 8'h0C);
    foreach (vq[i]) begin
      @(negedge clk);
      check($sformatf("vec%0d", i), {22'd0, tx_vld, tx_data, full, ovf},
            {22'd0, vq[i].vld, vq[i].data, 2'b00});
      drive(vq[i].av, vq[i].alu, vq[i].rv, vq[i].rd);
    end
    @(negedge clk);
    drive(1'b0, 16'h0, 1'b0, 8'h0);

    // Busy hold: byte must stay put until Busy drops.
    busy = 1'b1;
    drive(1'b0, 16'h0, 1'b1, 8'h5A);
    @(negedge clk);
    drive(1'b0, 16'h0, 1'b0, 8'h0);
    check("hold_latency", 32'(tx_vld), 32'd0);
    @(negedge clk);
    check("hold_first", {23'd0, tx_vld, tx_data}, {23'd0, 1'b1, 8'h5A});
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("hold_c%0d", c), {23'd0, tx_vld, tx_data}, {23'd0, 1'b1, 8'h5A});
    end
    busy = 1'b0;
    @(negedge clk);
    check("hold_released_gap", 32'(tx_vld), 32'd0);
    expect_quiet(4, "hold_done_quiet");

    // Mid-operation reset abandons the in-flight entry.
    busy = 1'b1;
    drive(1'b1, 16'hCAFE, 1'b0, 8'h0);
    @(negedge clk);
    drive(1'b0, 16'h0, 1'b0, 8'h0);
    @(negedge clk);
    check("midrst_pre", {23'd0, tx_vld, tx_data}, {23'd0, 1'b1, 8'hFE});
    rst = 1'b0;
    @(negedge clk);
    rst  = 1'b1;
    busy = 1'b0;
    check("midrst_outputs", {21'd0, tx_vld, tx_data, full, ovf}, 32'd0);
    expect_quiet(6, "midrst_no_resend");

    // Overflow: one ALU entry parked in Send, then five Rd pulses into four slots.
    busy = 1'b1;
    drive(1'b1, 16'hCAFE, 1'b0, 8'h0);
    @(negedge clk);
    drive(1'b0, 16'h0, 1'b0, 8'h0);
    @(negedge clk);
    check("ovf_parked", {23'd0, tx_vld, tx_data}, {23'd0, 1'b1, 8'hFE});
    for (int k = 1; k <= 5; k++) begin
      drive(1'b0, 16'h0, 1'b1, 8'(k));
      @(negedge clk);
      if (k == 4) check("ovf_full_at4", {30'd0, full, ovf}, {30'd0, 2'b10});
    end
    drive(1'b0, 16'h0, 1'b0, 8'h0);
    check("ovf_flags", {30'd0, full, ovf}, {30'd0, 2'b11});
    check("ovf_still_fe", {23'd0, tx_vld, tx_data}, {23'd0, 1'b1, 8'hFE});
    busy = 1'b0;
    @(negedge clk);
    exp = '{8'hCA, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00};
    drain(exp, 5, "ovf_drain");
    expect_quiet(8, "ovf_fifth_dropped");
    check("ovf_sticky", {30'd0, full, ovf}, {30'd0, 2'b01});

    // One free slot with ALU+Rd together: ALU kept, Rd dropped.
    rst = 1'b0;
    @(negedge clk);
    rst  = 1'b1;
    busy = 1'b1;
    drive(1'b1, 16'hAA55, 1'b0, 8'h0);
    @(negedge clk);
    drive(1'b0, 16'h0, 1'b0, 8'h0);
    @(negedge clk);
    for (int k = 1; k <= 3; k++) begin
      drive(1'b0, 16'h0, 1'b1, 8'(k));
      @(negedge clk);
    end
    drive(1'b1, 16'h1111, 1'b1, 8'h77);
    @(negedge clk);
    drive(1'b0, 16'h0, 1'b0, 8'h0);
    check("split_flags", {30'd0, full, ovf}, {30'd0, 2'b11});
    check("split_head", {23'd0, tx_vld, tx_data}, {23'd0, 1'b1, 8'h55});
    busy = 1'b0;
    @(negedge clk);
    exp = '{8'hAA, 8'h01, 8'h02, 8'h03, 8'h11, 8'h11, 8'h00, 8'h00};
    drain(exp, 6, "split_drain");
    expect_quiet(8, "split_rd_dropped");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
